audio_clk_gen: RTL
==================

Name: audio_clk_gen

Overview:
- Generates bclk (bit clock) and word_clk (frame/LR clock) from the master clock mclkin.
- Generalises the fixed-ratio word clock divider in three ways: run-time bclk ratio and frame length, a selectable word-clock mode (50% I2S/left-justified or one-bit DSP/TDM pulse), and an enable with clean frame-boundary start/stop.
- Sits at the top of the audio datapath; serialisers and deserialisers consume its outputs and strobes.

Parameters:
- DIV_W, 4: width of half_div; max bclk half-period = 2^DIV_W-1 mclk cycles.
- SLOT_W, 9: width of frame_len and bit_idx; max frame = 2^SLOT_W-1 bclk periods.

Ports:
- mclkin, input, 1: master clock; sole clock.
- rst, input, 1: reset; asynchronous, active-high.
- en, input, 1: run request.
- half_div, input, DIV_W: mclk cycles per bclk half-period (N). 0 is treated as 1.
- frame_len, input, SLOT_W: bclk periods per frame (L). Values 0 and 1 are treated as 2.
- mode, input, 1: 0 = 50% word clock; 1 = one-bclk pulse.
- bclk, output, 1: bit clock.
- word_clk, output, 1: frame clock.
- frame_start, output, 1: one-mclk pulse in the first mclk cycle of each frame.
- bclk_rise, output, 1: one-mclk strobe, high in the cycle that bclk goes 0->1.
- bclk_fall, output, 1: one-mclk strobe, high in the cycle that bclk goes 1->0.
- bit_idx, output, SLOT_W: index of the current bclk period, 0..L-1.
- running, output, 1: high while frames are being generated.

Behaviour:
- Reset (async assert): all outputs 0, all counters 0, state IDLE. Release is synchronous to mclkin.
- All outputs are registered and change only on posedge mclkin.
- Shadow registers latch half_div, frame_len and mode (after clamping) only at a frame start. Changes mid-frame have no effect until the next frame.
- States:
  - IDLE: bclk = word_clk = 0, running = 0, bit_idx = 0, strobes 0.
  - IDLE -> RUN: on the first mclkin edge with en = 1. That edge is frame start: shadows load, frame_start = 1, running = 1, bit_idx = 0, bclk = 0, word_clk = mode.
  - RUN: half counter hc counts 0..N-1.
    - hc wraps with bclk = 0: bclk -> 1, bclk_rise = 1.
    - hc wraps with bclk = 1: bclk -> 0, bclk_fall = 1, and a period ends.
  - Period end with bit_idx < L-1: bit_idx increments.
  - Period end with bit_idx = L-1 and en = 1: new frame start (as above); bit_idx = 0.
  - Period end with bit_idx = L-1 and en = 0: go to IDLE on that edge, outputs as in IDLE.
- en deassertion mid-frame always completes the current frame; no truncated frames.
- word_clk changes only on edges where a period starts, so it is aligned with the bclk falling edge.
  - mode 0: 0 for periods 0..floor(L/2)-1, 1 for periods floor(L/2)..L-1. L = 5 gives 2 low, 3 high.
  - mode 1: 1 during period 0 only.
- Period = 2N mclk cycles; frame = 2NL mclk cycles.
- Clamping happens before latching; bit_idx never reaches L.
- en asserted on the same edge the last frame ends: treated as continuous RUN, no IDLE cycle.

Decomposition:
- Package audio_clk_pkg holds:
  - MODE_I2S = 1'b0 and MODE_DSP = 1'b1
  - the two-state enum for IDLE/RUN
  - the clamp minima: HALF_MIN = 1, FRAME_MIN = 2
- One sub-module, bclk_half_div: the hc counter plus the bclk toggle and strobes. It has a load input for the shadow N and a sync-clear input. The top level owns the frame counter, word_clk, shadow registers and FSM.

Test Plan:
- Basic ratio: N=1, L=4, mode=0, en held high.
  - bclk period is 2 mclk; frame is 8 mclk.
  - word_clk is 4 low then 4 high, repeating.
  - frame_start pulses every 8 cycles.
- DSP pulse: N=2, L=8, mode=1.
  - bclk period is 4 mclk.
  - word_clk is high for 4 mclk every 32.
  - bit_idx counts 0..7.
  - bclk_rise/bclk_fall each pulse once per 4 cycles.
- Odd frame and clamps:
  - L=5, mode=0: word_clk low 2 periods, high 3.
  - L=1 and N=0: behaves exactly as L=2, N=1.
- Config change mid-frame: N changes 1->3 at bit_idx=1 with L=4. The current frame still uses 2-mclk periods; the next frame_start uses 6-mclk periods.
- Stop/restart:
  - en drops at bit_idx=1 (L=4): the frame completes, running falls on the final period end, and outputs are 0.
  - en re-asserted in IDLE: frame_start follows on the next edge.
- Reset mid-frame: rst pulsed asynchronously between clock edges. All outputs go to 0 immediately. After release with en=1, a clean frame starts at bit_idx=0.

Source files
------------

// File: rtl/audio_clk_pkg.sv
// Shared constants and types for the audio clock generator.
package audio_clk_pkg;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_DSP = 1'b1;

  typedef enum logic {StIdle, StRun} state_e;

  localparam int unsigned HALF_MIN  = 1;
  localparam int unsigned FRAME_MIN = 2;

endpackage

// File: rtl/bclk_half_div.sv
// Half-period counter producing bclk and its edge strobes from mclkin.
module bclk_half_div
  import audio_clk_pkg::*;
#(
  parameter int unsigned DIV_W = 4
) (
  input  logic             mclkin,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [DIV_W-1:0] half_n,
  output logic             bclk,
  output logic             bclk_rise,
  output logic             bclk_fall,
  output logic             period_end
);

  logic [DIV_W-1:0] n_q, hc_q, hc_d;
  logic             bclk_d, rise_d, fall_d, wrap;

  assign wrap       = (hc_q == n_q - DIV_W'(1));
  assign period_end = wrap & bclk;

  always_comb begin
    hc_d   = hc_q;
    bclk_d = bclk;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (clr) begin
      hc_d   = '0;
      bclk_d = 1'b0;
    end else if (load) begin
      // Frame start: from RUN this coincides with the closing wrap, from IDLE bclk is already 0.
      hc_d   = '0;
      bclk_d = 1'b0;
      fall_d = bclk;
    end else if (wrap) begin
      hc_d   = '0;
      bclk_d = ~bclk;
      rise_d = ~bclk;
      fall_d = bclk;
    end else begin
      hc_d = hc_q + DIV_W'(1);
    end
  end

  always_ff @(posedge mclkin or posedge rst) begin
    if (rst) begin
      n_q       <= DIV_W'(HALF_MIN);
      hc_q      <= '0;
      bclk      <= 1'b0;
      bclk_rise <= 1'b0;
      bclk_fall <= 1'b0;
    end else begin
      if (load) n_q <= half_n;
      hc_q      <= hc_d;
      bclk      <= bclk_d;
      bclk_rise <= rise_d;
      bclk_fall <= fall_d;
    end
  end

endmodule

// File: rtl/audio_clk_gen.sv
// Bit clock and frame clock generator with run-time ratio, frame length and word-clock mode.
module audio_clk_gen
  import audio_clk_pkg::*;
#(
  parameter int unsigned DIV_W  = 4,
  parameter int unsigned SLOT_W = 9
) (
  input  logic              mclkin,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  half_div,
  input  logic [SLOT_W-1:0] frame_len,
  input  logic              mode,
  output logic              bclk,
  output logic              word_clk,
  output logic              frame_start,
  output logic              bclk_rise,
  output logic              bclk_fall,
  output logic [SLOT_W-1:0] bit_idx,
  output logic              running
);

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] bit_q, bit_d, bit_nxt, l_q, l_d, l_cl;
  logic [DIV_W-1:0]  n_cl;
  logic              mode_q, mode_d, wc_q, wc_d, fs_q, fs_d;
  logic              load, clr, start, period_end;

  assign n_cl    = (half_div == '0) ? DIV_W'(HALF_MIN) : half_div;
  assign l_cl    = (frame_len < SLOT_W'(FRAME_MIN)) ? SLOT_W'(FRAME_MIN) : frame_len;
  assign bit_nxt = bit_q + SLOT_W'(1);

  bclk_half_div #(
    .DIV_W(DIV_W)
  ) u_half_div (
    .mclkin    (mclkin),
    .rst       (rst),
    .clr       (clr),
    .load      (load),
    .half_n    (n_cl),
    .bclk      (bclk),
    .bclk_rise (bclk_rise),
    .bclk_fall (bclk_fall),
    .period_end(period_end)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    wc_d    = wc_q;
    fs_d    = 1'b0;
    l_d     = l_q;
    mode_d  = mode_q;
    load    = 1'b0;
    clr     = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) start = 1'b1;
        else    clr   = 1'b1;
      end
      StRun: begin
        if (period_end) begin
          if (bit_q == l_q - SLOT_W'(1)) begin
            if (en) begin
              start = 1'b1;
            end else begin
              state_d = StIdle;
              clr     = 1'b1;
              bit_d   = '0;
              wc_d    = 1'b0;
            end
          end else begin
            bit_d = bit_nxt;
            wc_d  = (mode_q == MODE_DSP) ? 1'b0 : (bit_nxt >= (l_q >> 1));
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // Frame start: clamped config is latched here and held for the whole frame.
    if (start) begin
      state_d = StRun;
      load    = 1'b1;
      fs_d    = 1'b1;
      bit_d   = '0;
      l_d     = l_cl;
      mode_d  = mode;
      wc_d    = (mode == MODE_DSP);
    end
  end

  always_ff @(posedge mclkin or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      bit_q   <= '0;
      l_q     <= SLOT_W'(FRAME_MIN);
      mode_q  <= MODE_I2S;
      wc_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      l_q     <= l_d;
      mode_q  <= mode_d;
      wc_q    <= wc_d;
      fs_q    <= fs_d;
    end
  end

  assign word_clk    = wc_q;
  assign frame_start = fs_q;
  assign bit_idx     = bit_q;
  assign running     = (state_q == StRun);

endmodule
